mem_load: RTL and testbench
===========================

MEM_LOAD -- requirements
Module: mem_load

Interface
REQ-001 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- module_start  in  1  one-cycle pulse that starts a 256-coefficient load.
- Rs_tdata  in  64  stream word carrying two coefficients: [22:0] the even coefficient, [54:32] the odd coefficient, with [31:23] and [63:55] ignored.
- Rs_tvalid  in  1  stream valid.
- Rs_tready  out  1  stream ready.
- coef_ena, coef_wea  out  1 each  BRAM port A enable and write-enable.
- coef_addra  out  8  BRAM port A address.
- coef_dina  out  23  BRAM port A write data.
- coef_enb, coef_web  out  1 each  BRAM port B enable and write-enable.
- coef_addrb  out  8  BRAM port B address.
- coef_dinb  out  23  BRAM port B write data.
- module_done  out  1  one-cycle pulse after the last coefficient pair is written.
REQ-002 Reset SHALL be synchronous and active-low on rst_n, and all logic SHALL run on the single clock clk.

Function
REQ-003 The state machine SHALL have three states: IDLE, LOAD and FLUSH.
REQ-004 In IDLE, module_start SHALL clear the 7-bit beat counter and move to LOAD, and any other input SHALL be ignored.
REQ-005 Rs_tready SHALL equal (state==LOAD) AND NOT module_start, combinationally.
REQ-006 A beat SHALL be accepted only on a cycle where Rs_tvalid and Rs_tready are both 1; at most one beat SHALL be accepted per cycle.
REQ-007 For the k-th accepted beat (k=0..127), in the following cycle the block SHALL register the BRAM outputs as follows:
- ena=enb=wea=web=1;
- addra=2k, addrb=2k+1;
- dina=Rs_tdata[22:0], dinb=Rs_tdata[54:32].
The write therefore has exactly one cycle of latency.
REQ-008 On any cycle with no accepted beat in the previous cycle, all enables and write-enables SHALL be 0; the address and data outputs SHALL hold their last values.
REQ-009 The beat counter SHALL increment on each accepted beat.
REQ-010 On acceptance of beat 127, the state SHALL move to FLUSH and Rs_tready SHALL be 0 from the next cycle onward.
REQ-011 FLUSH SHALL last one cycle, during which the final write (addresses 254 and 255) is issued. The block SHALL then return to IDLE, and module_done SHALL pulse high for exactly one cycle on the cycle after that final write.
REQ-012 A stall (Rs_tvalid=0) SHALL insert no write and SHALL NOT advance the counter, for an unbounded number of cycles.
REQ-013 A module_start arriving in LOAD or FLUSH SHALL restart the load:
- the counter is cleared and the state goes to LOAD;
- any beat presented on that cycle is not accepted;
- a write already registered still completes;
- no module_done is produced for the aborted load.
REQ-014 Addresses SHALL never wrap: the counter saturates at 127 and is never incremented past it.

Reset
REQ-015 While rst_n=0 the block SHALL force state=IDLE, counter=0 and Rs_tready=0.
REQ-016 While rst_n=0 the block SHALL force all enables and write-enables to 0, all addresses and data to 0, and module_done=0.
REQ-017 Reset asserted mid-load SHALL abandon the load with no further writes and no module_done.

Configuration
REQ-018 When the macro MEM_LOAD_COEF_REDUCE_EN is defined, each 23-bit coefficient c SHALL be written as (c >= 8380417) ? c - 8380417 : c. This is purely combinational inside the write register path and adds no latency.
REQ-019 When MEM_LOAD_COEF_REDUCE_EN is undefined, coefficients SHALL be written verbatim.

Structure
REQ-020 A shared package SHALL hold:
- DILITHIUM_Q = 23'd8380417;
- N_COEF = 256;
- N_BEATS = 128;
- the COEF_W = 23 width;
- the mem_load state encoding.
REQ-021 The conditional subtraction SHALL be one sub-module, coef_reduce, instantiated twice (once per lane) only when MEM_LOAD_COEF_REDUCE_EN is defined.

Verification
REQ-022 Full load: after reset and module_start, send 128 back-to-back beats {9'b0, 2k+1, 9'b0, 2k}. Required response: 128 consecutive dual writes, addr 0..255, data equal to address, then module_done high on exactly one cycle.
REQ-023 Stalls: Rs_tvalid is deasserted for 5 cycles after beats 0, 63 and 127. Required response: no write during the gaps and identical final BRAM contents.
REQ-024 Restart: module_start is issued after 40 beats, followed by 128 new beats with data 0x7FFFFF-k. Required response: addresses 0..255 hold the new data and only one module_done occurs.
REQ-025 Reset mid-load: rst_n=0 for 2 cycles after beat 10. Required response: the write-enables are 0 on the next cycle, Rs_tready=0, and module_done never asserts.
REQ-026 Reduction: send coefficients 8380416, 8380417 and 8388607. Required response with MEM_LOAD_COEF_REDUCE_EN defined: 8380416, 0 and 8190 are written. Required response without the macro: the values are written unchanged.
REQ-027 Padding and simultaneous events:
- bits [31:23] and [63:55] are set to all ones, and the required response is that the written data is unaffected;
- module_start coincides with a valid beat in LOAD, and the required response is Rs_tready=0 on that cycle.

Source files
------------

// File: rtl/mem_load_pkg.sv
// mem_load shared package: coefficient geometry, modulus and FSM state encoding.
package mem_load_pkg;

    localparam logic [22:0] DILITHIUM_Q = 23'd8380417;
    localparam int          N_COEF      = 256;
    localparam int          N_BEATS     = 128;
    localparam int          COEF_W      = 23;
    localparam int          ADDR_W      = $clog2(N_COEF);
    localparam int          BEAT_W      = $clog2(N_BEATS);
    localparam int          TDATA_W     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/mem_load_if.sv
// mem_load bus interface: coefficient input stream plus the dual-port BRAM write port.
// slave  = the loader (consumes the stream, drives the BRAM)
// master = the environment (drives the stream, observes the BRAM)
interface mem_load_if;
    import mem_load_pkg::*;

    logic [TDATA_W-1:0] Rs_tdata;
    logic               Rs_tvalid;
    logic               Rs_tready;

    logic               coef_ena;
    logic               coef_wea;
    logic [ADDR_W-1:0]  coef_addra;
    logic [COEF_W-1:0]  coef_dina;
    logic               coef_enb;
    logic               coef_web;
    logic [ADDR_W-1:0]  coef_addrb;
    logic [COEF_W-1:0]  coef_dinb;

    modport slave (
        input  Rs_tdata, Rs_tvalid,
        output Rs_tready,
        output coef_ena, coef_wea, coef_addra, coef_dina,
        output coef_enb, coef_web, coef_addrb, coef_dinb
    );

    modport master (
        output Rs_tdata, Rs_tvalid,
        input  Rs_tready,
        input  coef_ena, coef_wea, coef_addra, coef_dina,
        input  coef_enb, coef_web, coef_addrb, coef_dinb
    );

endinterface

// File: rtl/mem_load_coef_reduce.sv
// coef_reduce: single conditional subtraction of the Dilithium modulus.
// Only compiled when MEM_LOAD_COEF_REDUCE_EN is defined, since that is the
// only build in which mem_load instantiates it.
`ifdef MEM_LOAD_COEF_REDUCE_EN
module coef_reduce
    import mem_load_pkg::*;
(
    input  logic [COEF_W-1:0] coef_i,
    output logic [COEF_W-1:0] coef_o
);

    // Map [q, 2^23) down by one modulus; smaller values pass through.
    always_comb begin
        coef_o = coef_i;
        if (coef_i >= DILITHIUM_Q) begin
            coef_o = coef_i - DILITHIUM_Q;
        end else begin
            coef_o = coef_i;
        end
    end

endmodule
`endif

// File: rtl/mem_load.sv
// mem_load: unpacks a 128-beat stream of coefficient pairs into a dual-port
// BRAM (even coefficient on port A, odd on port B), one pair per beat.
// Optional feature macro: MEM_LOAD_COEF_REDUCE_EN -- when defined, each
// coefficient is conditionally reduced by q before being written.
module mem_load
    import mem_load_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      module_start,
    mem_load_if.slave bus,
    output logic      module_done
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    state_t              state_q;
    logic [BEAT_W-1:0]   cnt_q;
    logic                ena_q;
    logic                wea_q;
    logic                enb_q;
    logic                web_q;
    logic [ADDR_W-1:0]   addra_q;
    logic [ADDR_W-1:0]   addrb_q;
    logic [COEF_W-1:0]   dina_q;
    logic [COEF_W-1:0]   dinb_q;
    logic                done_q;

    logic                tready_s;
    logic                beat_acc_s;
    logic [COEF_W-1:0]   coef_even_s;
    logic [COEF_W-1:0]   coef_odd_s;
    logic [COEF_W-1:0]   wr_even_s;
    logic [COEF_W-1:0]   wr_odd_s;
    logic                unused_pad_s;

    assign coef_even_s  = bus.Rs_tdata[22:0];
    assign coef_odd_s   = bus.Rs_tdata[54:32];
    assign unused_pad_s = ^{bus.Rs_tdata[63:55], bus.Rs_tdata[31:23]};

`ifdef MEM_LOAD_COEF_REDUCE_EN
    coef_reduce u_reduce_even (
        .coef_i (coef_even_s),
        .coef_o (wr_even_s)
    );

    coef_reduce u_reduce_odd (
        .coef_i (coef_odd_s),
        .coef_o (wr_odd_s)
    );
`else
    assign wr_even_s = coef_even_s;
    assign wr_odd_s  = coef_odd_s;
`endif

    // Ready only while loading; a start pulse (restart) blocks acceptance,
    // and reset blocks it even before the state register has been cleared.
    always_comb begin
        tready_s   = rst_n && (state_q == LOAD) && !module_start;
        beat_acc_s = tready_s && bus.Rs_tvalid;
    end

    // Loader FSM: beat counting, registered BRAM write port and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
            wea_q   <= 1'b0;
            enb_q   <= 1'b0;
            web_q   <= 1'b0;
            addra_q <= '0;
            addrb_q <= '0;
            dina_q  <= '0;
            dinb_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            // Write strobes and done are single-cycle; addresses/data hold.
            ena_q  <= 1'b0;
            wea_q  <= 1'b0;
            enb_q  <= 1'b0;
            web_q  <= 1'b0;
            done_q <= 1'b0;
            if (module_start) begin
                // Start or restart from any state; an aborted load never
                // reaches FLUSH, so it never raises done.
                cnt_q   <= '0;
                state_q <= LOAD;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    LOAD: begin
                        if (beat_acc_s) begin
                            ena_q   <= 1'b1;
                            wea_q   <= 1'b1;
                            enb_q   <= 1'b1;
                            web_q   <= 1'b1;
                            addra_q <= {cnt_q, 1'b0};
                            addrb_q <= {cnt_q, 1'b1};
                            dina_q  <= wr_even_s;
                            dinb_q  <= wr_odd_s;
                            // Counter saturates on the last beat so the
                            // addresses can never wrap.
                            if (cnt_q == LAST_BEAT) begin
                                state_q <= FLUSH;
                            end else begin
                                cnt_q <= cnt_q + {{(BEAT_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                    FLUSH: begin
                        // Final pair is on the BRAM port this cycle.
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Rs_tready  = tready_s;
    assign bus.coef_ena   = ena_q;
    assign bus.coef_wea   = wea_q;
    assign bus.coef_addra = addra_q;
    assign bus.coef_dina  = dina_q;
    assign bus.coef_enb   = enb_q;
    assign bus.coef_web   = web_q;
    assign bus.coef_addrb = addrb_q;
    assign bus.coef_dinb  = dinb_q;
    assign module_done    = done_q;

endmodule

// File: tb/tb_mem_load.sv
// tb_mem_load: randomized and directed stimulus for mem_load, checked every
// cycle against a transaction-level model (beats accepted so far, pending
// done) plus literal expectations on the resulting BRAM image.
module tb_mem_load;
    import mem_load_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic module_start;
    logic module_done;

    mem_load_if bus ();

    mem_load dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .module_start (module_start),
        .bus          (bus),
        .module_done  (module_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;

    logic [22:0] mem_img [256];
    logic [22:0] exp_mem [256];

    // model state (owned by the model process)
    bit          m_active;
    int          m_k;
    bit          m_done_arm;
    logic        e_en;
    logic [7:0]  e_aa, e_ab;
    logic [22:0] e_da, e_db;
    logic        e_done;
    logic        e_rdy;
    bit          m_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] red(input logic [22:0] c);
`ifdef MEM_LOAD_COEF_REDUCE_EN
        return (c >= 23'd8380417) ? c - 23'd8380417 : c;
`else
        return c;
`endif
    endfunction

    function automatic logic [63:0] word(input logic [22:0] lo, input logic [22:0] hi,
                                         input logic [8:0] pad);
        return {pad, hi, pad, lo};
    endfunction

    // Model + compare: at each negedge the inputs are those the next posedge
    // will sample; check current outputs, then predict the next ones.
    initial begin : model
        m_active = 1'b0; m_k = 0; m_done_arm = 1'b0;
        e_en = 1'b0; e_aa = 8'd0; e_ab = 8'd0; e_da = 23'd0; e_db = 23'd0; e_done = 1'b0;
        forever begin
            @(negedge clk);
            chk("ena",   bus.coef_ena,   e_en);
            chk("wea",   bus.coef_wea,   e_en);
            chk("enb",   bus.coef_enb,   e_en);
            chk("web",   bus.coef_web,   e_en);
            chk("addra", bus.coef_addra, e_aa);
            chk("addrb", bus.coef_addrb, e_ab);
            chk("dina",  bus.coef_dina,  e_da);
            chk("dinb",  bus.coef_dinb,  e_db);
            chk("done",  module_done,    e_done);
            e_rdy = rst_n && m_active && !module_start;
            chk("tready", bus.Rs_tready, e_rdy);
            if (bus.coef_ena && bus.coef_wea) begin
                mem_img[bus.coef_addra] = bus.coef_dina;
                wr_cnt++;
            end
            if (bus.coef_enb && bus.coef_web) begin
                mem_img[bus.coef_addrb] = bus.coef_dinb;
                wr_cnt++;
            end
            if (module_done) done_cnt++;
            if (!rst_n) begin
                m_active = 1'b0; m_k = 0; m_done_arm = 1'b0;
                e_en = 1'b0; e_aa = 8'd0; e_ab = 8'd0; e_da = 23'd0; e_db = 23'd0;
                e_done = 1'b0;
            end else begin
                m_acc  = e_rdy && bus.Rs_tvalid;
                e_en   = m_acc;
                e_done = m_done_arm && !module_start;
                m_done_arm = 1'b0;
                if (m_acc) begin
                    e_aa = 8'(2 * m_k);
                    e_ab = 8'(2 * m_k + 1);
                    e_da = red(bus.Rs_tdata[22:0]);
                    e_db = red(bus.Rs_tdata[54:32]);
                end
                if (module_start) begin
                    m_active = 1'b1;
                    m_k = 0;
                end else if (m_acc) begin
                    m_k++;
                    if (m_k == N_BEATS) begin
                        m_active   = 1'b0;
                        m_done_arm = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        module_start = 1'b1;
        tick();
        module_start = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [63:0] d);
        logic r;
        int   cyc;
        bus.Rs_tdata  = d;
        bus.Rs_tvalid = 1'b1;
        cyc = 0;
        r   = 1'b0;
        while (!r && cyc < 50) begin
            @(negedge clk);
            r = bus.Rs_tready;
            tick();
            cyc++;
        end
        bus.Rs_tvalid = 1'b0;
        if (!r) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_mem(input string nm);
        int errs = 0;
        for (int i = 0; i < N_COEF; i++) begin
            if (mem_img[i] !== exp_mem[i]) errs++;
        end
        chk(nm, errs, 0);
    endtask

    initial begin : driver
        int d0, w0, cut;
        logic [22:0] lo, hi;
        rst_n         = 1'b0;
        module_start  = 1'b0;
        bus.Rs_tdata  = 64'd0;
        bus.Rs_tvalid = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // S1: full back-to-back load, data equals address
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        for (int k = 0; k < N_BEATS; k++) send(word(23'(2*k), 23'(2*k+1), 9'h000));
        idle(4);
        for (int i = 0; i < N_COEF; i++) exp_mem[i] = 23'(i);
        check_mem("s1_mem");
        chk("s1_done", done_cnt - d0, 1);
        chk("s1_writes", wr_cnt - w0, 256);
        chk("s1_mem255", mem_img[255], 23'd255);
        chk("s1_mem0", mem_img[0], 23'd0);

        // S2: stalls after beats 0, 63, 127 with all-ones padding
        d0 = done_cnt; w0 = wr_cnt;
        pulse_start();
        for (int k = 0; k < N_BEATS; k++) begin
            send(word(23'(2*k), 23'(2*k+1), 9'h1FF));
            if (k == 0 || k == 63 || k == 127) idle(5);
        end
        idle(4);
        check_mem("s2_mem");
        chk("s2_done", done_cnt - d0, 1);
        chk("s2_writes", wr_cnt - w0, 256);

        // S3: restart after 40 beats, start coinciding with a valid beat
        d0 = done_cnt;
        pulse_start();
        for (int k = 0; k < 40; k++) send(word(23'($urandom), 23'($urandom), 9'($urandom)));
        module_start  = 1'b1;
        bus.Rs_tvalid = 1'b1;
        bus.Rs_tdata  = word(23'h123456, 23'h654321, 9'h000);
        @(negedge clk);
        chk("s3_start_ready", bus.Rs_tready, 1'b0);
        tick();
        module_start  = 1'b0;
        bus.Rs_tvalid = 1'b0;
        for (int k = 0; k < N_BEATS; k++)
            send(word(23'h7FFFFF - 23'(2*k), 23'h7FFFFF - 23'(2*k+1), 9'h000));
        idle(4);
        for (int i = 0; i < N_COEF; i++) exp_mem[i] = 23'h7FFFFF - 23'(i);
        check_mem("s3_mem");
        chk("s3_done", done_cnt - d0, 1);
        chk("s3_mem1", mem_img[1], 23'h7FFFFE);

        // S4: reset for 2 cycles after beat 10
        d0 = done_cnt;
        pulse_start();
        for (int k = 0; k <= 10; k++) send(word(23'($urandom), 23'($urandom), 9'h000));
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("s4_wea", bus.coef_wea, 1'b0);
        chk("s4_web", bus.coef_web, 1'b0);
        chk("s4_ready", bus.Rs_tready, 1'b0);
        tick();
        rst_n = 1'b1;
        bus.Rs_tvalid = 1'b1;
        idle(10);
        bus.Rs_tvalid = 1'b0;
        chk("s4_no_done", done_cnt - d0, 0);

        // S5: reduction boundary values, then random gaps/data/padding
        d0 = done_cnt;
        pulse_start();
        send(word(23'd8380416, 23'd8380417, 9'h000));
        exp_mem[0] = red(23'd8380416); exp_mem[1] = red(23'd8380417);
        send(word(23'd8388607, 23'd5, 9'h1FF));
        exp_mem[2] = red(23'd8388607); exp_mem[3] = 23'd5;
        for (int k = 2; k < N_BEATS; k++) begin
            lo = 23'($urandom); hi = 23'($urandom);
            exp_mem[2*k] = red(lo); exp_mem[2*k+1] = red(hi);
            send(word(lo, hi, 9'($urandom)));
            idle($urandom_range(0, 2));
        end
        idle(4);
        check_mem("s5_mem");
        chk("s5_done", done_cnt - d0, 1);
        chk("s5_c0", mem_img[0], 23'd8380416);
`ifdef MEM_LOAD_COEF_REDUCE_EN
        chk("s5_c1", mem_img[1], 23'd0);
        chk("s5_c2", mem_img[2], 23'd8190);
`else
        chk("s5_c1", mem_img[1], 23'd8380417);
        chk("s5_c2", mem_img[2], 23'd8388607);
`endif

        // S6: random loads, each preceded by a random-length aborted load
        for (int r = 0; r < 3; r++) begin
            d0 = done_cnt;
            pulse_start();
            cut = $urandom_range(1, 126);
            for (int k = 0; k < cut; k++) send(word(23'($urandom), 23'($urandom), 9'($urandom)));
            pulse_start();
            for (int k = 0; k < N_BEATS; k++) begin
                lo = 23'($urandom); hi = 23'($urandom);
                if (r == 0) begin
                    lo = 23'($urandom_range(8380410, 8388607));
                    hi = 23'($urandom_range(8380410, 8388607));
                end
                exp_mem[2*k] = red(lo); exp_mem[2*k+1] = red(hi);
                send(word(lo, hi, 9'($urandom)));
                idle($urandom_range(0, 1));
            end
            idle(4);
            check_mem("s6_mem");
            chk("s6_done", done_cnt - d0, 1);
        end

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
